inert_intf: RTL and testbench

INERT_INTF -- requirements
Module: inert_intf

---
 rtl/inert_intf.sv | 148 ++++++++++++++
 tb/tb_inert_intf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_intf.sv
// Inertial sensor front end: powers up the gyro/accel over SPI, reads pitch rate and
// Y acceleration on every data-ready, and fuses them into a pitch estimate for the PID.
module inert_intf #(
  parameter int                 TMR_W          = 16,
  parameter logic signed [15:0] PTCH_RT_OFFSET = 16'sh0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] ptch,
  output logic        vld
);

  typedef enum logic [3:0] {
    WAIT_PWR, INIT1, INIT2, INIT3, INIT4, IDLE,
    RD_RL, RD_RH, RD_AL, RD_AH, CALC
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               int_ff_q, int_s_q;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic [7:0]         rl_q, rl_d, rh_q, rh_d, al_q, al_d, ah_q, ah_d;
  logic signed [15:0] ptch_rt_q, ptch_rt_d;
  logic signed [15:0] ptch_q, ptch_d;
  logic signed [26:0] ptch_int_q, ptch_int_d;
  logic               upd_q, upd_d;
  logic               vld_q, vld_d;

  logic               adv;
  logic signed [15:0] rate;
  logic signed [15:0] ay;
  logic signed [25:0] ay_prod;
  logic signed [15:0] ptch_acc;
  logic signed [26:0] fus;
  logic [7:0]         rd_hi_unused;

  assign rd_hi_unused = rd_data[15:8];

  // A done sampled while wrt is still high belongs to the previous transaction.
  assign adv = done && !wrt_q;

  assign rate     = $signed({rh_q, rl_q}) - PTCH_RT_OFFSET;
  assign ay       = $signed({ah_q, al_q});
  assign ay_prod  = 26'(ay) * 26'sd327;
  assign ptch_acc = 16'(ay_prod >>> 13);
  assign fus      = (ptch_acc > ptch_q) ? 27'sd1024 : -27'sd1024;

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d    = state_q;
    tmr_d      = tmr_q;
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    rl_d       = rl_q;
    rh_d       = rh_q;
    al_d       = al_q;
    ah_d       = ah_q;
    ptch_rt_d  = ptch_rt_q;
    ptch_int_d = ptch_int_q;
    ptch_d     = upd_q ? ptch_int_q[26:11] : ptch_q;
    upd_d      = 1'b0;
    vld_d      = upd_q;

    case (state_q)
      WAIT_PWR: begin
        tmr_d = tmr_q + 1'b1;
        if (&tmr_q) begin
          state_d = INIT1; wrt_d = 1'b1; cmd_d = 16'h0D02;
        end
      end
      INIT1: if (adv) begin state_d = INIT2; wrt_d = 1'b1; cmd_d = 16'h1160; end
      INIT2: if (adv) begin state_d = INIT3; wrt_d = 1'b1; cmd_d = 16'h1250; end
      INIT3: if (adv) begin state_d = INIT4; wrt_d = 1'b1; cmd_d = 16'h1460; end
      INIT4: if (adv) state_d = IDLE;
      IDLE:  if (int_s_q) begin state_d = RD_RL; wrt_d = 1'b1; cmd_d = 16'hA200; end
      RD_RL: if (adv) begin
        rl_d = rd_data[7:0]; state_d = RD_RH; wrt_d = 1'b1; cmd_d = 16'hA300;
      end
      RD_RH: if (adv) begin
        rh_d = rd_data[7:0]; state_d = RD_AL; wrt_d = 1'b1; cmd_d = 16'hAA00;
      end
      RD_AL: if (adv) begin
        al_d = rd_data[7:0]; state_d = RD_AH; wrt_d = 1'b1; cmd_d = 16'hAB00;
      end
      RD_AH: if (adv) begin
        ah_d = rd_data[7:0]; state_d = CALC;
      end
      CALC: begin
        ptch_rt_d  = rate;
        ptch_int_d = ptch_int_q - 27'(rate) + fus;
        upd_d      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = WAIT_PWR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_PWR;
      tmr_q      <= '0;
      int_ff_q   <= 1'b0;
      int_s_q    <= 1'b0;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      rl_q       <= 8'h00;
      rh_q       <= 8'h00;
      al_q       <= 8'h00;
      ah_q       <= 8'h00;
      ptch_rt_q  <= 16'sh0000;
      ptch_q     <= 16'sh0000;
      ptch_int_q <= 27'sh0;
      upd_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      int_ff_q   <= INT;
      int_s_q    <= int_ff_q;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      rl_q       <= rl_d;
      rh_q       <= rh_d;
      al_q       <= al_d;
      ah_q       <= ah_d;
      ptch_rt_q  <= ptch_rt_d;
      ptch_q     <= ptch_d;
      ptch_int_q <= ptch_int_d;
      upd_q      <= upd_d;
      vld_q      <= vld_d;
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign ptch_rt = ptch_rt_q;
  assign ptch    = ptch_q;
  assign vld     = vld_q;

endmodule

// File: tb/tb_inert_intf.sv
// Self-checking bench for inert_intf: two instances (rate offset 0 and 0x0010) share one
// SPI responder; expected results go into a scoreboard and are compared on each vld.
module tb_inert_intf;

  localparam int BUDGET = 64;

  logic        clk, rst, int_in, done;
  logic [15:0] rd_data;
  logic        wrt0, wrt1, vld0, vld1;
  logic [15:0] cmd0, cmd1, ptch_rt0, ptch_rt1, ptch0, ptch1;

  typedef struct {
    logic [15:0] rt0, p0, rt1, p1;
  } exp_t;

  typedef struct {
    logic [7:0] rl, rh, al, ah;
    exp_t       e;
  } vec_t;

  exp_t               sb[$];
  vec_t               vecs[6];
  int                 checks, errors;
  logic signed [26:0] pint0, pint1;
  logic [15:0]        pm0, pm1;

  inert_intf #(.TMR_W(4), .PTCH_RT_OFFSET(16'sh0000)) dut0 (
    .clk(clk), .rst(rst), .INT(int_in), .done(done), .rd_data(rd_data),
    .wrt(wrt0), .cmd(cmd0), .ptch_rt(ptch_rt0), .ptch(ptch0), .vld(vld0)
  );

  inert_intf #(.TMR_W(4), .PTCH_RT_OFFSET(16'sh0010)) dut1 (
    .clk(clk), .rst(rst), .INT(int_in), .done(done), .rd_data(rd_data),
    .wrt(wrt1), .cmd(cmd1), .ptch_rt(ptch_rt1), .ptch(ptch1), .vld(vld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] rl, rh, al, ah,
                              input logic [15:0] rt0, p0, rt1, p1);
    vec_t v;
    v.rl = rl; v.rh = rh; v.al = al; v.ah = ah;
    v.e.rt0 = rt0; v.e.p0 = p0; v.e.rt1 = rt1; v.e.p1 = p1;
    return v;
  endfunction

  // Reference arithmetic for one read sequence, done in plain integers.
  task automatic model_step(input logic [15:0] off, input logic [7:0] rl, rh, al, ah,
                            inout logic signed [26:0] pint, inout logic [15:0] p,
                            output logic [15:0] rt);
    int          r, ay, acc, fus;
    longint      ni;
    logic [15:0] raw, accel;
    raw   = {rh, rl};
    accel = {ah, al};
    r     = int'($signed(raw)) - int'($signed(off));
    rt    = r[15:0];
    ay    = int'($signed(accel));
    acc   = (ay * 327) >>> 13;
    fus   = (acc > int'($signed(p))) ? 1024 : -1024;
    ni    = longint'(pint) - longint'($signed(rt)) + longint'(fus);
    pint  = ni[26:0];
    p     = pint[26:11];
  endtask

  task automatic next_exp(input logic [7:0] rl, rh, al, ah, output exp_t e);
    logic [15:0] rt;
    model_step(16'h0000, rl, rh, al, ah, pint0, pm0, rt);
    e.rt0 = rt; e.p0 = pm0;
    model_step(16'h0010, rl, rh, al, ah, pint1, pm1, rt);
    e.rt1 = rt; e.p1 = pm1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (vld0 || vld1) begin
      check("vld_pair", vld1, vld0);
      if (sb.size() == 0) check("unexpected_vld", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        check("ptch_rt0", ptch_rt0, e.rt0);
        check("ptch0", ptch0, e.p0);
        check("ptch_rt1", ptch_rt1, e.rt1);
        check("ptch1", ptch1, e.p1);
      end
    end
  end

  task automatic wait_wrt(output int n);
    n = 0;
    while (!wrt0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Serve one SPI command: check it, optionally send a done inside the wrt cycle, then a real done.
  task automatic spi_cmd(input logic [15:0] exp_cmd, input logic [7:0] b, input bit early,
                         output int n);
    wait_wrt(n);
    check("wrt_timeout", n < BUDGET, 1);
    check("cmd0", cmd0, exp_cmd);
    check("cmd1", cmd1, exp_cmd);
    if (early) done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("wrt_one_cycle", wrt0, 0);
    repeat (3) @(negedge clk);
    done    = 1'b1;
    rd_data = {8'hA5, b};
    @(negedge clk);
    done    = 1'b0;
    rd_data = 16'h0000;
  endtask

  task automatic do_reset(input bit int_val);
    rst = 1'b1; done = 1'b0; int_in = int_val; rd_data = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_wrt", {wrt0, wrt1}, 0);
    check("rst_cmd", {cmd0, cmd1}, 0);
    check("rst_vld", {vld0, vld1}, 0);
    check("rst_ptch", {ptch0, ptch1}, 0);
    check("rst_ptch_rt", {ptch_rt0, ptch_rt1}, 0);
    pint0 = '0; pint1 = '0; pm0 = '0; pm1 = '0;
    rst = 1'b0;
  endtask

  task automatic init_seq(input int exp_wait);
    int n;
    spi_cmd(16'h0D02, 8'h00, 1'b0, n);
    check("pwr_wait", n, exp_wait);
    spi_cmd(16'h1160, 8'h00, 1'b1, n);
    spi_cmd(16'h1250, 8'h00, 1'b0, n);
    spi_cmd(16'h1460, 8'h00, 1'b0, n);
  endtask

  task automatic read_seq(input logic [7:0] rl, rh, al, ah, input exp_t e,
                          input bit keep_int, output int n_first);
    int n;
    sb.push_back(e);
    int_in = 1'b1;
    spi_cmd(16'hA200, rl, 1'b0, n_first);
    if (!keep_int) int_in = 1'b0;
    spi_cmd(16'hA300, rh, 1'b0, n);
    spi_cmd(16'hAA00, al, 1'b0, n);
    spi_cmd(16'hAB00, ah, 1'b0, n);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("vld_timeout", n < 20, 1);
    @(negedge clk);
    check("vld_one_cycle", vld0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;
    checks = 0; errors = 0;
    rst = 1'b1; int_in = 1'b0; done = 1'b0; rd_data = 16'h0000;

    // Each vector runs from reset, so ptch and ptch_int start at zero.
    vecs[0] = mk(8'h34, 8'h12, 8'h00, 8'h00, 16'h1234, 16'hFFFD, 16'h1224, 16'hFFFD);
    vecs[1] = mk(8'h10, 8'h00, 8'h00, 8'h00, 16'h0010, 16'hFFFF, 16'h0000, 16'hFFFF);
    vecs[2] = mk(8'h00, 8'hF0, 8'h00, 8'h10, 16'hF000, 16'h0002, 16'hEFF0, 16'h0002);
    vecs[3] = mk(8'h00, 8'h80, 8'h00, 8'hF0, 16'h8000, 16'h000F, 16'h7FF0, 16'hFFEF);
    vecs[4] = mk(8'h10, 8'h00, 8'h1A, 8'h00, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    vecs[5] = mk(8'h10, 8'h00, 8'h19, 8'h00, 16'h0010, 16'hFFFF, 16'h0000, 16'hFFFF);

    for (int i = 0; i < 6; i++) begin
      do_reset(1'b0);
      init_seq(16);
      read_seq(vecs[i].rl, vecs[i].rh, vecs[i].al, vecs[i].ah, vecs[i].e, 1'b0, n);
      drain();
    end

    // INT high through init, then two back-to-back sequences.
    do_reset(1'b1);
    init_seq(16);
    next_exp(8'h34, 8'h12, 8'h00, 8'h00, e);
    read_seq(8'h34, 8'h12, 8'h00, 8'h00, e, 1'b1, n);
    check("rd_after_init4", n + 2, 3);
    next_exp(8'h00, 8'hF0, 8'h00, 8'h10, e);
    read_seq(8'h00, 8'hF0, 8'h00, 8'h10, e, 1'b0, n);
    check("idle_between_seqs", n, 2);
    drain();

    // Stray done pulses in IDLE with INT low.
    for (int k = 0; k < 3; k++) begin
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check("idle_done_wrt", wrt0, 0);
      end
    end
    check("idle_hold_ptch0", ptch0, e.p0);
    check("idle_hold_ptch_rt0", ptch_rt0, e.rt0);
    check("idle_hold_ptch1", ptch1, e.p1);
    next_exp(8'h20, 8'h00, 8'h00, 8'h08, e);
    read_seq(8'h20, 8'h00, 8'h00, 8'h08, e, 1'b0, n);
    drain();

    // Reset during RD_AL, followed by a late done.
    int_in = 1'b1;
    spi_cmd(16'hA200, 8'h55, 1'b0, n);
    int_in = 1'b0;
    spi_cmd(16'hA300, 8'h01, 1'b0, n);
    wait_wrt(n);
    check("rd_al_cmd", cmd0, 16'hAA00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; done = 1'b1; rd_data = 16'h00FF;
    @(negedge clk);
    done = 1'b0; rd_data = 16'h0000;
    check("abort_wrt", wrt0, 0);
    check("abort_cmd", cmd0, 16'h0000);
    check("abort_ptch", {ptch0, ptch1}, 0);
    check("abort_ptch_rt", {ptch_rt0, ptch_rt1}, 0);
    check("abort_vld", vld0, 0);
    pint0 = '0; pint1 = '0; pm0 = '0; pm1 = '0;
    init_seq(15);
    next_exp(8'h10, 8'h00, 8'h00, 8'h00, e);
    read_seq(8'h10, 8'h00, 8'h00, 8'h00, e, 1'b0, n);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
